// File: rtl/arb_requester_bank.sv
//==============================================================================
// Module  : arb_requester_bank
// Brief   : Four-channel job holder that requests a rotating-priority arbiter,
//           runs the granted channel's burst on a shared beat bus, then acks.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module arb_requester_bank #(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           job_valid,
    input  logic [4*LEN_W-1:0]   job_len,
    output logic [3:0]           job_ready,
    output logic [3:0]           req,
    input  logic [3:0]           grant,
    output logic                 ack,
    output logic                 bus_valid,
    output logic [1:0]           bus_chan,
    output logic [LEN_W-1:0]     bus_beat,
    output logic                 bus_last,
    input  logic                 bus_ready,
    output logic                 busy,
    output logic                 err_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        pend_q, pend_d;
    logic [LEN_W-1:0]  len_q [4];
    logic [LEN_W-1:0]  len_d [4];
    logic [1:0]        owner_q, owner_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              w_last;
    logic              w_grant_legal;
    logic [1:0]        w_grant_idx;

    // A grant is only honoured when it names exactly one channel that holds a job.
    assign w_grant_legal = $onehot(grant) && ((grant & ~pend_q) == 4'b0000);
    assign w_last        = (cnt_q == len_q[owner_q]);

    always_comb begin
        w_grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                w_grant_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pend_d  = pend_q | (job_valid & ~pend_q);
        len_d   = len_q;
        for (int i = 0; i < 4; i++) begin
            if (job_valid[i] && !pend_q[i]) begin
                len_d[i] = job_len[i*LEN_W +: LEN_W];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant != 4'b0000) begin
                    if (w_grant_legal) begin
                        owner_d = w_grant_idx;
                        cnt_d   = '0;
                        state_d = ST_XFER;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (bus_ready) begin
                    if (w_last) begin
                        // Owner slot is never accepting here, so no set/clear clash.
                        pend_d[owner_q] = 1'b0;
                        state_d         = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 4'b0000;
            owner_q <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    assign job_ready = ~pend_q;
    assign req       = pend_q;
    assign ack       = (state_q == ST_ACK);
    assign bus_valid = (state_q == ST_XFER);
    assign bus_chan  = bus_valid ? owner_q : 2'd0;
    assign bus_beat  = bus_valid ? cnt_q : '0;
    assign bus_last  = bus_valid && w_last;
    assign busy      = (state_q != ST_IDLE);
    assign err_grant = err_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_requester_bank.sv
//==============================================================================
// Module  : tb_arb_requester_bank
// Brief   : Randomised bench with a rotating-priority arbiter stand-in and a
//           transaction-level reference model of the requester bank.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_arb_requester_bank;

    localparam int LEN_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           job_valid;
    logic [4*LEN_W-1:0]   job_len;
    logic [3:0]           job_ready;
    logic [3:0]           req;
    logic [3:0]           grant;
    logic                 ack;
    logic                 bus_valid;
    logic [1:0]           bus_chan;
    logic [LEN_W-1:0]     bus_beat;
    logic                 bus_last;
    logic                 bus_ready;
    logic                 busy;
    logic                 err_grant;

    logic                 force_en;
    logic [3:0]           force_val;

    arb_requester_bank #(.LEN_W(LEN_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req       (req),
        .grant     (grant),
        .ack       (ack),
        .bus_valid (bus_valid),
        .bus_chan  (bus_chan),
        .bus_beat  (bus_beat),
        .bus_last  (bus_last),
        .bus_ready (bus_ready),
        .busy      (busy),
        .err_grant (err_grant)
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: highest priority at ptr, moves past the served channel on ack.
    logic [1:0] arb_ptr;
    logic [1:0] arb_own;
    logic [3:0] arb_grant;
    logic       arb_found;

    always_comb begin
        arb_grant = 4'b0000;
        arb_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!arb_found && req[2'(arb_ptr + 2'(k))]) begin
                arb_grant[2'(arb_ptr + 2'(k))] = 1'b1;
                arb_found = 1'b1;
            end
        end
        grant = force_en ? force_val : arb_grant;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_ptr <= 2'd0;
            arb_own <= 2'd0;
        end else begin
            if (bus_valid) arb_own <= bus_chan;
            if (ack)       arb_ptr <= arb_own + 2'd1;
        end
    end

    // Reference model: job table plus the burst currently being delivered.
    bit [3:0] m_pend;
    int       m_len [4];
    int       m_owner;     // -1 when no burst is in progress
    int       m_done;      // beats already delivered of the current burst
    bit       m_ack;       // burst finished, release cycle in progress
    bit       m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_owner = -1;
        m_done  = 0;
        m_ack   = 0;
        m_err   = 0;
        for (int i = 0; i < 4; i++) m_len[i] = 0;
    endtask

    task automatic model_update();
        bit [3:0] old_pend;
        int       idx;
        old_pend = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (job_valid[i] && !old_pend[i]) begin
                m_pend[i] = 1'b1;
                m_len[i]  = int'(job_len[i*LEN_W +: LEN_W]);
            end
        end
        if (m_ack) begin
            m_ack   = 0;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            if (bus_ready) begin
                if (m_done == m_len[m_owner]) begin
                    m_pend[m_owner] = 1'b0;
                    m_ack           = 1;
                end else begin
                    m_done++;
                end
            end
        end else if (grant != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (grant[i]) idx = i;
            if ($countones(grant) == 1 && old_pend[idx]) begin
                m_owner = idx;
                m_done  = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit       xfer;
        bit [3:0] exp_ready;
        xfer      = (m_owner >= 0) && !m_ack;
        exp_ready = ~m_pend;
        check("job_ready", {28'd0, job_ready}, {28'd0, exp_ready});
        check("req",       {28'd0, req},       {28'd0, m_pend});
        check("ack",       {31'd0, ack},       {31'd0, m_ack});
        check("bus_valid", {31'd0, bus_valid}, {31'd0, xfer});
        check("bus_chan",  {30'd0, bus_chan},  xfer ? m_owner : 0);
        check("bus_beat",  {28'd0, bus_beat},  xfer ? m_done : 0);
        check("bus_last",  {31'd0, bus_last},  (xfer && m_done == m_len[m_owner]) ? 1 : 0);
        check("busy",      {31'd0, busy},      (m_owner >= 0) ? 1 : 0);
        check("err_grant", {31'd0, err_grant}, {31'd0, m_err});
    endtask

    task automatic step();
        @(negedge clk);
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_idle();
        job_valid = 4'b0000;
        job_len   = '0;
        bus_ready = 1'b1;
        force_en  = 1'b0;
        force_val = 4'b0000;
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) job_valid[i] = ($urandom_range(0, 9) < 3);
        job_len   = 16'($urandom);
        bus_ready = ($urandom_range(0, 3) != 0);
        // Garbage grants only while a burst owns the bus, where they must be ignored.
        force_en  = (m_owner >= 0) && ($urandom_range(0, 4) == 0);
        force_val = 4'($urandom);
    endtask

    initial begin
        int guard;
        drive_idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // Single short job on channel 2.
        job_valid = 4'b0100;
        job_len   = 16'h0000;
        step();
        drive_idle();
        repeat (5) step();

        // All four channels at once, two beats each.
        job_valid = 4'b1111;
        job_len   = 16'h1111;
        step();
        drive_idle();
        repeat (14) step();

        // Channel 1, four beats, stalled on beat 1.
        job_valid = 4'b0010;
        job_len   = 16'h0030;
        step();
        drive_idle();
        step();
        step();
        bus_ready = 1'b0;
        step();
        step();
        bus_ready = 1'b1;
        repeat (6) step();

        for (int n = 0; n < 3000; n++) begin
            drive_random();
            step();
        end

        drive_idle();
        repeat (80) step();

        // Illegal two-hot grant while idle.
        force_en  = 1'b1;
        force_val = 4'b0011;
        step();
        force_en  = 1'b0;
        repeat (3) step();

        // Reset in the middle of a burst.
        job_valid = 4'b0010;
        job_len   = 16'h00F0;
        step();
        drive_idle();
        bus_ready = 1'b0;
        guard = 0;
        while (!((m_owner >= 0) && !m_ack) && guard < 20) begin
            step();
            guard++;
        end
        check("midburst_reached", (guard < 20) ? 1 : 0, 1);
        bus_ready = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1;
        rst = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arb_requester_bank.md
Name: arb_requester_bank

Overview:
- Requester-side companion to the team's 4-way rotating-priority arbiter.
- Holds up to one pending job per channel (4 channels) and drives the arbiter's req[3:0].
- Consumes the arbiter's combinational grant[3:0] and runs the granted channel's burst on a shared beat bus.
- Pulses the arbiter's shared ack input for one cycle to release the bus and rotate arbiter priority.

Parameters:
LEN_W, 4, width of per-channel burst length field; burst beats = job_len+1 (1..2^LEN_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
job_valid  input  4  per-channel job offer
job_len  input  4*LEN_W  per-channel burst length minus one, channel i at bits [i*LEN_W +: LEN_W]
job_ready  output  4  per-channel job acceptance (channel slot empty)
req  output  4  request vector to arbiter
grant  input  4  grant vector from arbiter (combinational, expected one-hot or zero)
ack  output  1  one-cycle release pulse to arbiter
bus_valid  output  1  beat presented on shared bus
bus_chan  output  2  channel index owning current beat
bus_beat  output  LEN_W  beat index within burst, 0-based
bus_last  output  1  current beat is final beat of burst
bus_ready  input  1  downstream accepts beat
busy  output  1  bus FSM not in IDLE
err_grant  output  1  sticky illegal-grant flag

Behaviour:
- Reset (rst=0, async):
  - pend=0, so job_ready=4'b1111 and req=0.
  - ack=0, bus_valid=0, bus_chan=0, bus_beat=0, bus_last=0, busy=0, err_grant=0.
  - FSM=IDLE.
- Reset mid-burst aborts the burst with no ack; the arbiter is reset on the same rst.
- Channel slots:
  - job_ready[i]=~pend[i].
  - A job is accepted on job_valid[i]&job_ready[i] at a clock edge: pend[i] sets and len_q[i] latches job_len slice.
  - req[i]=pend[i] (registered, no combinational path from job_valid).
- Bus FSM: IDLE, XFER, ACK.
  - IDLE:
    - Legal grant (exactly one bit set and that channel pending) at an edge: owner<=index, cnt<=0, go to XFER.
    - grant==0: stay in IDLE.
    - grant with >1 bit set, or a bit set for a non-pending channel: set err_grant, stay in IDLE, start no transfer.
  - XFER:
    - Outputs: bus_valid=1, bus_chan=owner, bus_beat=cnt, bus_last=(cnt==len_q[owner]).
    - Beat holds stable while bus_ready=0.
    - On bus_ready with !bus_last: cnt++.
    - On bus_ready with bus_last: pend[owner] clears and go to ACK.
    - grant is ignored throughout XFER; owner is latched, so a grant change mid-burst never switches channels.
  - ACK:
    - ack=1 for exactly this one cycle; bus_valid=0.
    - req[owner] is already 0 in this cycle.
    - grant is ignored; go to IDLE next edge.
- Timing:
  - ack is asserted only in ACK state, never two consecutive cycles.
  - The arbiter ring advances on that edge, so the next IDLE cycle sees the rotated grant.
- Latency:
  - Job accepted at edge N: req high from cycle N+1.
  - With the bus idle and grant legal in cycle N+1, the first beat is valid in cycle N+2.
  - A burst with zero stalls occupies len+1 XFER cycles plus 1 ACK cycle.
- Re-request: the owner channel may accept a new job during the ACK cycle (job_ready=1). Its req rises the following cycle and competes normally under rotated priority.
- Simultaneous events: job acceptance on any non-owner channel is independent of bus FSM activity.
- busy=1 in XFER and ACK.
- err_grant is cleared only by reset.

Test Plan:
- Single job, channel 2, job_len=0, bus_ready=1, grant=4'b0100 while req[2]=1 -> one beat with bus_chan=2, bus_beat=0, bus_last=1, then ack=1 for one cycle, req=0, job_ready=4'b1111.
- All four channels offered in the same cycle, job_len=1 each, arbiter model starting priority at channel 0 -> bursts run in order 0,1,2,3, each 2 beats followed by 1 ack cycle; exactly 4 ack pulses total.
- Channel 1, job_len=3, bus_ready low for 2 cycles on beat 1 -> bus_beat stays 1 with bus_valid=1 during the stall; 4 beats delivered in total; bus_last only on beat 3.
- During channel 0's burst, grant switches to 4'b0010 -> bus_chan stays 0 to completion and no err_grant.
- Channel 3 offers a new job during its own ACK cycle -> job_ready[3]=1 and accepted; req[3]=1 the next cycle; channel 0 (pending) is served before channel 3 under rotated priority.
- Two further checks:
  - grant=4'b0011 in IDLE -> err_grant=1 sticky, busy stays 0.
  - rst pulsed low mid-burst -> all outputs return to reset values immediately with no ack.
